// File: rtl/wash_cycle_ctrl_pkg.sv
// Shared definitions for the washing-machine sequencer: the state
// encoding seen by the LED display, and small helpers that describe
// how the wash programme moves from one phase to the next.
package wash_cycle_ctrl_pkg;

  // State codes are part of the display interface and must not change.
  typedef enum logic [2:0] {
    ST_FREE   = 3'b000,
    ST_SUPPLY = 3'b001,
    ST_RINSE  = 3'b011,
    ST_DRAIN  = 3'b010,
    ST_DEHYD  = 3'b110,
    ST_WARN   = 3'b100
  } wm_state_t;

  // True for the four phases that run against the seconds countdown.
  function automatic logic is_timed(input wm_state_t s);
    case (s)
      ST_SUPPLY, ST_RINSE, ST_DRAIN, ST_DEHYD: return 1'b1;
      default:                                 return 1'b0;
    endcase
  endfunction

  // Phase that follows a timed phase once its countdown expires.
  // Draining loops back to supply while more rinse rounds remain.
  function automatic wm_state_t after_phase(input wm_state_t s,
                                            input logic [1:0] rounds);
    case (s)
      ST_SUPPLY: return ST_RINSE;
      ST_RINSE:  return ST_DRAIN;
      ST_DRAIN:  return (rounds > 2'd1) ? ST_SUPPLY : ST_DEHYD;
      ST_DEHYD:  return ST_FREE;
      default:   return ST_FREE;
    endcase
  endfunction

  // Seconds loaded into the countdown on entry to a phase; zero for
  // anything that is not a timed phase.
  function automatic logic [7:0] phase_secs(input wm_state_t s,
                                            input logic [7:0] t_supply,
                                            input logic [7:0] t_rinse,
                                            input logic [7:0] t_drain,
                                            input logic [7:0] t_dehyd);
    case (s)
      ST_SUPPLY: return t_supply;
      ST_RINSE:  return t_rinse;
      ST_DRAIN:  return t_drain;
      ST_DEHYD:  return t_dehyd;
      default:   return 8'd0;
    endcase
  endfunction

endpackage

// File: rtl/wash_cycle_ctrl_sec_prescaler.sv
// One-second time base for the sequencer. A counter divides the system
// clock down to a half-second and toggles the displayed square wave.
// After a restart the wave sits high for a full half-second, then low for
// a full half-second; the wrap that ends the low half closes one complete
// second, and that is where the tick is raised, so a phase of T seconds
// spans exactly T*CLK_HZ clocks from its entry.
module sec_prescaler #(
  parameter int CLK_HZ = 24_000_000
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic second,
  output logic tick
);

  localparam int HALF = CLK_HZ / 2;
  localparam int W    = (HALF > 1) ? $clog2(HALF) : 1;
  localparam logic [W-1:0] LAST = W'(HALF - 1);

  logic [W-1:0] cnt_r;
  logic         second_r;

  // Half-second counter and square-wave toggle; restart realigns both.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_r    <= '0;
      second_r <= 1'b1;
    end else if (restart) begin
      cnt_r    <= '0;
      second_r <= 1'b1;
    end else if (cnt_r == LAST) begin
      cnt_r    <= '0;
      second_r <= ~second_r;
    end else begin
      cnt_r    <= cnt_r + W'(1);
      second_r <= second_r;
    end
  end

  assign second = second_r;
  // Raised on the last clock of the low half, i.e. a full second elapsed.
  assign tick   = (cnt_r == LAST) & ~second_r;

endmodule

// File: rtl/wash_cycle_ctrl.sv
// Washing-machine sequencer. Runs ROUNDS supply/rinse/drain rounds, then
// dehydrates, then returns to Free. Opening the lid during any timed phase
// parks the machine in Warning with the countdown frozen; an ack with the
// lid closed resumes the interrupted phase where it left off.
module wash_cycle_ctrl
  import wash_cycle_ctrl_pkg::*;
#(
  parameter int CLK_HZ   = 24_000_000,
  parameter int T_SUPPLY = 10,
  parameter int T_RINSE  = 20,
  parameter int T_DRAIN  = 10,
  parameter int T_DEHYD  = 15,
  parameter int ROUNDS   = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       lid_open,
  input  logic       ack,
  output logic [2:0] state,
  output logic       second,
  output logic       clr,
  output logic [7:0] sec_left,
  output logic [1:0] round_left,
  output logic       done
);

  localparam logic [7:0] SEC_SUPPLY = 8'(T_SUPPLY);
  localparam logic [7:0] SEC_RINSE  = 8'(T_RINSE);
  localparam logic [7:0] SEC_DRAIN  = 8'(T_DRAIN);
  localparam logic [7:0] SEC_DEHYD  = 8'(T_DEHYD);
  localparam logic [1:0] ROUNDS_LD  = 2'(ROUNDS);

  wm_state_t  state_r;
  wm_state_t  state_nxt_s;
  wm_state_t  resume_r;
  wm_state_t  resume_nxt_s;
  logic [7:0] sec_r;
  logic [7:0] sec_nxt_s;
  logic [1:0] round_r;
  logic [1:0] round_nxt_s;
  logic       done_r;
  logic       done_nxt_s;
  logic       clr_r;
  logic       tick_s;
  logic       second_s;
  logic       timed_s;
  logic       expire_s;
  logic       change_s;

  assign timed_s  = is_timed(state_r);
  // A tick on the last remaining second ends the phase instead of counting.
  assign expire_s = timed_s & tick_s & (sec_r == 8'd1);
  // Every state change restarts the time base so the new phase gets full seconds.
  assign change_s = (state_nxt_s != state_r);

  sec_prescaler #(
    .CLK_HZ (CLK_HZ)
  ) u_prescaler (
    .clk     (clk),
    .rst     (rst),
    .restart (change_s),
    .second  (second_s),
    .tick    (tick_s)
  );

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r <= ST_FREE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state selection; lid_open takes priority over an expiring phase.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_FREE: begin
        if (start) begin
          state_nxt_s = ST_SUPPLY;
        end else begin
          state_nxt_s = ST_FREE;
        end
      end
      ST_SUPPLY, ST_RINSE, ST_DRAIN, ST_DEHYD: begin
        if (lid_open) begin
          state_nxt_s = ST_WARN;
        end else if (expire_s) begin
          state_nxt_s = after_phase(state_r, round_r);
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_WARN: begin
        if (ack && !lid_open) begin
          state_nxt_s = resume_r;
        end else begin
          state_nxt_s = ST_WARN;
        end
      end
      default: begin
        state_nxt_s = ST_FREE;
      end
    endcase
  end

  // Countdown, round counter, resume point and done pulse for the next clock.
  always_comb begin
    sec_nxt_s    = sec_r;
    round_nxt_s  = round_r;
    resume_nxt_s = resume_r;
    done_nxt_s   = 1'b0;
    case (state_r)
      ST_FREE: begin
        if (start) begin
          sec_nxt_s   = SEC_SUPPLY;
          round_nxt_s = ROUNDS_LD;
        end else begin
          sec_nxt_s   = sec_r;
          round_nxt_s = round_r;
        end
      end
      ST_SUPPLY, ST_RINSE, ST_DRAIN, ST_DEHYD: begin
        if (lid_open) begin
          // Countdown and rounds stay frozen while the lid is open.
          resume_nxt_s = state_r;
        end else if (expire_s) begin
          sec_nxt_s = phase_secs(state_nxt_s, SEC_SUPPLY, SEC_RINSE,
                                 SEC_DRAIN, SEC_DEHYD);
          if (state_r == ST_DRAIN && round_r > 2'd1) begin
            round_nxt_s = round_r - 2'd1;
          end else if (state_r == ST_DEHYD) begin
            round_nxt_s = 2'd0;
            done_nxt_s  = 1'b1;
          end else begin
            round_nxt_s = round_r;
          end
        end else if (tick_s && sec_r > 8'd1) begin
          sec_nxt_s = sec_r - 8'd1;
        end else begin
          sec_nxt_s = sec_r;
        end
      end
      ST_WARN: begin
        // Resuming keeps the frozen countdown; nothing to load here.
        sec_nxt_s = sec_r;
      end
      default: begin
        sec_nxt_s    = 8'd0;
        round_nxt_s  = 2'd0;
        resume_nxt_s = ST_FREE;
      end
    endcase
  end

  // Datapath registers holding countdown, rounds and the resume point.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sec_r    <= 8'd0;
      round_r  <= 2'd0;
      resume_r <= ST_FREE;
    end else begin
      sec_r    <= sec_nxt_s;
      round_r  <= round_nxt_s;
      resume_r <= resume_nxt_s;
    end
  end

  // Display strobes: clr low for the clock after each state change, done pulse.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      clr_r  <= 1'b1;
      done_r <= 1'b0;
    end else begin
      clr_r  <= ~change_s;
      done_r <= done_nxt_s;
    end
  end

  assign state      = state_r;
  assign second     = second_s;
  assign clr        = clr_r;
  assign sec_left   = sec_r;
  assign round_left = round_r;
  assign done       = done_r;

endmodule

// File: tb/tb_wash_cycle_ctrl.sv
// Self-checking bench for wash_cycle_ctrl. A behavioural model tracks the
// programme in terms of phases, seconds and clocks elapsed since the last
// phase change; every clock all outputs are compared to it. Directed
// scenarios cover the called-out corner cases, then random stimulus runs.
module tb_wash_cycle_ctrl;

  localparam int HZ = 20;
  localparam int TS = 2, TR = 3, TD = 2, TH = 2, NR = 2;
  localparam logic [2:0] S_FREE = 3'b000, S_SUP = 3'b001, S_RIN = 3'b011,
                         S_DRN = 3'b010, S_DEH = 3'b110, S_WRN = 3'b100;

  logic clk = 1'b0, rst = 1'b0, start = 1'b0, lid_open = 1'b0, ack = 1'b0;
  logic [2:0] state;
  logic       second, clr, done;
  logic [7:0] sec_left;
  logic [1:0] round_left;

  int n_tests = 0, n_fail = 0, cyc = 0;

  // model state
  logic [2:0] m_state = S_FREE, m_resume = S_FREE;
  int m_sec = 0, m_round = 0, m_el = 0;
  bit m_clr = 1'b1, m_done = 1'b0;

  // recording for the full-cycle check
  bit rec = 1'b0;
  int t_q[$];
  int s_q[$];
  int n_done = 0, n_clr = 0;
  logic [2:0] prev_state = S_FREE;

  wash_cycle_ctrl #(
    .CLK_HZ(HZ), .T_SUPPLY(TS), .T_RINSE(TR), .T_DRAIN(TD), .T_DEHYD(TH), .ROUNDS(NR)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .lid_open(lid_open), .ack(ack),
    .state(state), .second(second), .clr(clr), .sec_left(sec_left),
    .round_left(round_left), .done(done)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input int obs, input int exp_v);
    n_tests++;
    if (obs !== exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (cycle %0d)", tag, obs, exp_v, cyc);
    end
  endtask

  function automatic int dur(input logic [2:0] s);
    case (s)
      S_SUP:   return TS;
      S_RIN:   return TR;
      S_DRN:   return TD;
      S_DEH:   return TH;
      default: return 0;
    endcase
  endfunction

  task automatic model_reset();
    m_state = S_FREE; m_resume = S_FREE; m_sec = 0; m_round = 0;
    m_el = 0; m_clr = 1'b1; m_done = 1'b0;
  endtask

  // One clock of the programme rules, applied to the inputs at this edge.
  task automatic model_step();
    logic [2:0] nxt;
    int nsec, nround;
    bit sec_tick;
    nxt = m_state; nsec = m_sec; nround = m_round;
    sec_tick = ((m_el % HZ) == HZ - 1);
    m_done = 1'b0;
    if (m_state == S_FREE) begin
      if (start) begin nxt = S_SUP; nround = NR; nsec = TS; end
    end else if (m_state == S_WRN) begin
      if (ack && !lid_open) nxt = m_resume;
    end else if (lid_open) begin
      nxt = S_WRN; m_resume = m_state;
    end else if (sec_tick) begin
      if (m_sec > 1) nsec = m_sec - 1;
      else begin
        if (m_state == S_SUP) nxt = S_RIN;
        else if (m_state == S_RIN) nxt = S_DRN;
        else if (m_state == S_DRN) begin
          if (m_round > 1) begin nxt = S_SUP; nround = m_round - 1; end
          else nxt = S_DEH;
        end else begin
          nxt = S_FREE; nround = 0; m_done = 1'b1;
        end
        nsec = dur(nxt);
      end
    end
    m_clr = (nxt == m_state);
    m_el = (nxt != m_state) ? 0 : m_el + 1;
    m_state = nxt; m_sec = nsec; m_round = nround;
  endtask

  task automatic compare_all();
    check_val("state", state, m_state);
    check_val("sec_left", sec_left, m_sec);
    check_val("round_left", round_left, m_round);
    check_val("second", second, ((m_el % HZ) < HZ / 2) ? 1 : 0);
    check_val("clr", clr, m_clr);
    check_val("done", done, m_done);
  endtask

  // Advance one clock: model follows the edge, outputs compared just after.
  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst) model_step();
    #1;
    compare_all();
    if (rec) begin
      if (state != prev_state) begin t_q.push_back(cyc); s_q.push_back(int'(state)); end
      if (done) n_done++;
      if (!clr) n_clr++;
    end
    prev_state = state;
    @(negedge clk);
  endtask

  task automatic pulse_start();
    start = 1'b1; step(); start = 1'b0;
  endtask

  task automatic run_until_free(input int budget);
    int i;
    for (i = 0; i < budget && m_state != S_FREE; i++) step();
    if (m_state != S_FREE) check_val("timeout_free", 0, 1);
  endtask

  initial begin
    int exp_seq[8];
    int cnt;
    bit hit;
    exp_seq = '{1, 3, 2, 1, 3, 2, 6, 0};
    model_reset();
    repeat (3) @(posedge clk);
    #1; compare_all();
    @(negedge clk); rst = 1'b1;

    // 1: idle after reset
    repeat (100) step();

    // 2: full cycle with phase lengths
    rec = 1'b1; n_done = 0; n_clr = 0; t_q.delete(); s_q.delete();
    pulse_start();
    repeat (330) step();
    rec = 1'b0;
    check_val("n_changes", t_q.size(), 8);
    check_val("n_done", n_done, 1);
    check_val("n_clr_low", n_clr, 8);
    for (int i = 0; i < 8 && i < s_q.size(); i++) check_val("seq_state", s_q[i], exp_seq[i]);
    for (int i = 0; i < 7 && i + 1 < t_q.size(); i++)
      check_val("phase_len", t_q[i+1] - t_q[i], dur(3'(exp_seq[i])) * HZ);

    // 3: lid open in Rinsing at 2 s left, ack ignored while open, resume
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (m_state == S_RIN && m_sec == 2 && (m_el % HZ) != HZ - 1) hit = 1'b1;
      else step();
    end
    check_val("reach_rinse2", hit, 1);
    lid_open = 1'b1; step();
    check_val("warn_entry", state, S_WRN);
    check_val("warn_sec", sec_left, 2);
    repeat (5) step();
    ack = 1'b1; step(); ack = 1'b0;
    check_val("ack_lid_open", state, S_WRN);
    lid_open = 1'b0; ack = 1'b1; step(); ack = 1'b0;
    check_val("resume_state", state, S_RIN);
    check_val("resume_sec", sec_left, 2);
    cnt = 0;
    while (state == S_RIN && cnt < 100) begin step(); cnt++; end
    check_val("resume_len", cnt, 2 * HZ);
    run_until_free(500);

    // 4: lid open on the expiry tick of Water_supply
    pulse_start();
    hit = 1'b0;
    for (int i = 0; i < 300 && !hit; i++) begin
      if (m_state == S_SUP && m_sec == 1 && (m_el % HZ) == HZ - 1) hit = 1'b1;
      else step();
    end
    check_val("reach_sup_tick", hit, 1);
    lid_open = 1'b1; step(); lid_open = 1'b0;
    check_val("tick_lid_warn", state, S_WRN);
    check_val("tick_lid_sec", sec_left, 1);
    ack = 1'b1; step(); ack = 1'b0;
    check_val("tick_resume", state, S_SUP);
    cnt = 0;
    while (state == S_SUP && cnt < 100) begin step(); cnt++; end
    check_val("tick_resume_len", cnt, HZ);
    run_until_free(500);

    // 5: start ignored outside Free, lid ignored in Free, start+lid together
    pulse_start();
    for (int i = 0; i < 200 && m_state != S_RIN; i++) step();
    pulse_start();
    check_val("start_in_rinse", state, S_RIN);
    run_until_free(500);
    lid_open = 1'b1; repeat (3) step();
    check_val("lid_in_free", state, S_FREE);
    start = 1'b1; step(); start = 1'b0;
    check_val("start_lid_sup", state, S_SUP);
    step();
    check_val("start_lid_warn", state, S_WRN);
    lid_open = 1'b0; ack = 1'b1; step(); ack = 1'b0;
    run_until_free(500);

    // 6: asynchronous reset during Dehydrating, then a normal cycle
    pulse_start();
    for (int i = 0; i < 400 && m_state != S_DEH; i++) step();
    check_val("reach_dehyd", state, S_DEH);
    #2 rst = 1'b0;
    #1;
    model_reset();
    check_val("arst_state", state, S_FREE);
    check_val("arst_sec", sec_left, 0);
    check_val("arst_round", round_left, 0);
    check_val("arst_second", second, 1);
    @(negedge clk);
    repeat (2) step();
    rst = 1'b1;
    pulse_start();
    run_until_free(500);

    // random stimulus
    for (int i = 0; i < 3000; i++) begin
      start = ($urandom_range(0, 39) == 0);
      ack   = ($urandom_range(0, 7) == 0);
      if (!lid_open && $urandom_range(0, 59) == 0) lid_open = 1'b1;
      else if (lid_open && $urandom_range(0, 5) == 0) lid_open = 1'b0;
      step();
    end
    start = 1'b0; ack = 1'b0; lid_open = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
